// File: rtl/wb_trace_recorder.sv
// wb_trace_recorder: captures {PC, write-back data} pairs from the core into a
// circular buffer. Sampling is either periodic or on each write-back event.
// Capture is one-shot or wrap-around, and a random-access port reads the buffer back.
module wb_trace_recorder #(
    parameter int PC_W     = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int INTERVAL = 5,
    parameter int WRAP     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       sample_mode,
    input  logic [PC_W-1:0]            pc_in,
    input  logic [DATA_W-1:0]          wb_data_in,
    input  logic                       wb_valid,
    input  logic                       rd_en,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [PC_W-1:0]            rd_pc,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);
    // state     | meaning
    // S_IDLE    | after reset, nothing captured yet
    // S_CAPTURE | armed, taking samples
    // S_DONE    | capture ended by stop or by a full one-shot buffer

    localparam int AW = $clog2(DEPTH);
    localparam int IW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IW-1:0] INT_LAST = IW'(INTERVAL - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_LAST = (AW + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_mode;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic [IW-1:0]     r_int;
    logic [PC_W-1:0]   r_pc_mem   [DEPTH];
    logic [DATA_W-1:0] r_data_mem [DEPTH];
    logic [PC_W-1:0]   r_rd_pc;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    logic              w_sample;
    logic [AW-1:0]     w_base;
    logic [AW-1:0]     w_phys;

    // Sample strobe: interval terminal count in periodic mode, wb_valid in event mode
    always_comb begin
        w_sample = 1'b0;
        if (r_state == S_CAPTURE)
            w_sample = r_mode ? wb_valid : (r_int == INT_LAST);
    end

    // Logical-to-physical read index; once wrapped, the oldest entry sits at wr_ptr
    always_comb begin
        w_base = r_overflow ? r_wr_ptr : '0;
        w_phys = w_base + rd_addr;
    end

    // Capture FSM with write pointer, fill count, overflow flag and interval counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mode     <= 1'b0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_int      <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_CAPTURE;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_mode     <= sample_mode;
                        r_wr_ptr   <= '0;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                        r_int      <= '0;
                    end
                end
                S_CAPTURE: begin
                    r_int <= (r_int == INT_LAST) ? '0 : r_int + 1'b1;
                    if (w_sample) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_count != CNT_FULL)
                            r_count <= r_count + 1'b1;
                        else if (WRAP != 0)
                            r_overflow <= 1'b1;
                    end
                    // A one-shot buffer stops on the very edge that stores its last entry
                    if (stop || (w_sample && (WRAP == 0) && (r_count == CNT_LAST))) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Buffer storage; contents are not cleared by reset
    always_ff @(posedge clk) begin
        if (w_sample) begin
            r_pc_mem[r_wr_ptr]   <= pc_in;
            r_data_mem[r_wr_ptr] <= wb_data_in;
        end
    end

    // Registered readout; unfilled indices read as zero, same-cycle writes are not seen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_pc    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                if ({1'b0, rd_addr} >= r_count) begin
                    r_rd_pc   <= '0;
                    r_rd_data <= '0;
                end else begin
                    r_rd_pc   <= r_pc_mem[w_phys];
                    r_rd_data <= r_data_mem[w_phys];
                end
            end
        end
    end

    assign rd_pc    = r_rd_pc;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign done     = r_done;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_wb_trace_recorder.sv
// Directed bench for wb_trace_recorder: one default one-shot instance and one
// DEPTH=4 wrap-around instance sharing clock and reset.
module tb_wb_trace_recorder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 0, stop = 0, mode = 0, wb_valid = 0, rd_en = 0;
    logic [31:0] pc_in = 0, wb_data = 0;
    logic [4:0]  rd_addr = 0;
    logic [31:0] rd_pc, rd_data;
    logic        rd_valid, busy, done, overflow;
    logic [5:0]  count;

    logic        q_start = 0, q_stop = 0, q_mode = 0, q_wb_valid = 0, q_rd_en = 0;
    logic [31:0] q_pc_in = 0, q_wb_data = 0;
    logic [1:0]  q_rd_addr = 0;
    logic [31:0] q_rd_pc, q_rd_data;
    logic        q_rd_valid, q_busy, q_done, q_overflow;
    logic [2:0]  q_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_trace_recorder u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .sample_mode(mode),
        .pc_in(pc_in), .wb_data_in(wb_data), .wb_valid(wb_valid),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_pc(rd_pc), .rd_data(rd_data),
        .rd_valid(rd_valid), .busy(busy), .done(done), .count(count),
        .overflow(overflow)
    );

    wb_trace_recorder #(.DEPTH(4), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .start(q_start), .stop(q_stop), .sample_mode(q_mode),
        .pc_in(q_pc_in), .wb_data_in(q_wb_data), .wb_valid(q_wb_valid),
        .rd_en(q_rd_en), .rd_addr(q_rd_addr), .rd_pc(q_rd_pc), .rd_data(q_rd_data),
        .rd_valid(q_rd_valid), .busy(q_busy), .done(q_done), .count(q_count),
        .overflow(q_overflow)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3 rst = 1'b0;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%0h exp=0", done); end
        n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%0h exp=0", rd_valid); end
        n_checks++; if (rd_pc !== 32'd0 || rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd got=%0h/%0h exp=0/0", rd_pc, rd_data); end
        n_checks++; if (q_count !== 3'd0 || q_busy !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%0d/%0h exp=0/0", q_count, q_busy); end
        rst = 1'b1;
        tick();
    endtask

    // start during cycle 0; pc_in = 4*cycle, wb_data = cycle
    task automatic test_periodic;
        for (int c = 0; c <= 170; c++) begin
            start   = (c == 0);
            mode    = 1'b0;
            pc_in   = 32'(4 * c);
            wb_data = 32'(c);
            tick();
            if (c == 0) begin
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL per_busy got=%0h exp=1", busy); end
            end
            if (c == 4) begin
                n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL per_count_c4 got=%0d exp=0", count); end
            end
            if (c == 5) begin
                n_checks++; if (count !== 6'd1) begin n_fail++; $display("FAIL per_count_c5 got=%0d exp=1", count); end
            end
            if (c == 159) begin
                n_checks++; if (done !== 1'b0 || count !== 6'd31) begin n_fail++; $display("FAIL per_c159 got=%0h/%0d exp=0/31", done, count); end
            end
            if (c == 160) begin
                n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL per_done got=%0h/%0h exp=1/0", done, busy); end
            end
        end
        start = 1'b0;
        n_checks++; if (count !== 6'd32) begin n_fail++; $display("FAIL per_count_final got=%0d exp=32", count); end
        rd_en = 1'b1; rd_addr = 5'd0; tick();
        n_checks++; if (rd_pc !== 32'h14 || rd_data !== 32'h5 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL per_rd0 got=%0h/%0h/%0h exp=14/5/1", rd_pc, rd_data, rd_valid); end
        rd_addr = 5'd1; tick();
        n_checks++; if (rd_pc !== 32'h28 || rd_data !== 32'ha) begin n_fail++; $display("FAIL per_rd1 got=%0h/%0h exp=28/a", rd_pc, rd_data); end
        rd_addr = 5'd31; tick();
        n_checks++; if (rd_pc !== 32'h280 || rd_data !== 32'ha0) begin n_fail++; $display("FAIL per_rd31 got=%0h/%0h exp=280/a0", rd_pc, rd_data); end
        rd_en = 1'b0; rd_addr = 5'd0; tick();
        n_checks++; if (rd_valid !== 1'b0 || rd_pc !== 32'h280) begin n_fail++; $display("FAIL per_rd_hold got=%0h/%0h exp=0/280", rd_valid, rd_pc); end
    endtask

    task automatic test_event;
        logic [31:0] vals [3];
        vals[0] = 32'ha; vals[1] = 32'hb; vals[2] = 32'hc;
        start = 1'b1; mode = 1'b1; tick();
        start = 1'b0; mode = 1'b0;
        n_checks++; if (count !== 6'd0 || busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL evt_restart got=%0d/%0h/%0h exp=0/1/0", count, busy, done); end
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; wb_data = vals[i]; pc_in = 32'h100 + 32'(i); tick();
        end
        wb_valid = 1'b0; stop = 1'b1; tick();
        stop = 1'b0;
        n_checks++; if (count !== 6'd3 || done !== 1'b1) begin n_fail++; $display("FAIL evt_count got=%0d/%0h exp=3/1", count, done); end
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; rd_addr = 5'(i); tick();
            n_checks++; if (rd_data !== vals[i] || rd_pc !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL evt_rd%0d got=%0h/%0h exp=%0h/%0h", i, rd_data, rd_pc, vals[i], 32'h100 + 32'(i)); end
        end
        rd_addr = 5'd3; tick();
        n_checks++; if (rd_data !== 32'd0 || rd_pc !== 32'd0 || rd_valid !== 1'b1) begin n_fail++; $display("FAIL evt_rd3 got=%0h/%0h/%0h exp=0/0/1", rd_data, rd_pc, rd_valid); end
        rd_en = 1'b0; tick();
    endtask

    task automatic test_restart_and_stop;
        start = 1'b1; mode = 1'b0; tick();
        start = 1'b0;
        n_checks++; if (count !== 6'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_clear got=%0d/%0h exp=0/1", count, busy); end
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (count !== 6'd1) begin n_fail++; $display("FAIL rst_first got=%0d exp=1", count); end
        start = 1'b1; tick();
        start = 1'b0;
        n_checks++; if (count !== 6'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL start_in_capture got=%0d/%0h exp=1/1", count, busy); end
        for (int i = 0; i < 3; i++) tick();
        n_checks++; if (count !== 6'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL pre_stop got=%0d/%0h exp=1/1", count, busy); end
        stop = 1'b1; start = 1'b1; tick();
        stop = 1'b0; start = 1'b0;
        n_checks++; if (count !== 6'd2 || done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_sample got=%0d/%0h/%0h exp=2/1/0", count, done, busy); end
        tick();
        n_checks++; if (count !== 6'd2 || done !== 1'b1) begin n_fail++; $display("FAIL stop_ignored_start got=%0d/%0h exp=2/1", count, done); end
    endtask

    task automatic test_wrap;
        q_start = 1'b1; q_mode = 1'b1; tick();
        q_start = 1'b0; q_mode = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            q_wb_valid = 1'b1; q_wb_data = 32'(i); q_pc_in = 32'h40 + 32'(i); tick();
            if (i == 4) begin
                n_checks++; if (q_count !== 3'd4 || q_overflow !== 1'b0 || q_busy !== 1'b1) begin n_fail++; $display("FAIL wrap_full got=%0d/%0h/%0h exp=4/0/1", q_count, q_overflow, q_busy); end
            end
            if (i == 5) begin
                n_checks++; if (q_overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf5 got=%0h exp=1", q_overflow); end
            end
        end
        q_wb_valid = 1'b0; q_stop = 1'b1; tick();
        q_stop = 1'b0;
        n_checks++; if (q_count !== 3'd4 || q_overflow !== 1'b1 || q_done !== 1'b1) begin n_fail++; $display("FAIL wrap_end got=%0d/%0h/%0h exp=4/1/1", q_count, q_overflow, q_done); end
        for (int i = 0; i < 4; i++) begin
            q_rd_en = 1'b1; q_rd_addr = 2'(i); tick();
            n_checks++; if (q_rd_data !== 32'(i + 3) || q_rd_pc !== 32'h43 + 32'(i)) begin n_fail++; $display("FAIL wrap_rd%0d got=%0h/%0h exp=%0h/%0h", i, q_rd_data, q_rd_pc, i + 3, 32'h43 + 32'(i)); end
        end
        q_rd_en = 1'b0; tick();
    endtask

    task automatic test_async_reset;
        start = 1'b1; mode = 1'b0; tick();
        start = 1'b0;
        for (int i = 0; i < 35; i++) tick();
        n_checks++; if (count !== 6'd7 || busy !== 1'b1) begin n_fail++; $display("FAIL ar_pre got=%0d/%0h exp=7/1", count, busy); end
        #2 rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL ar_flags got=%0h/%0h exp=0/0", busy, done); end
        n_checks++; if (count !== 6'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL ar_count got=%0d/%0h exp=0/0", count, overflow); end
        n_checks++; if (q_overflow !== 1'b0 || q_count !== 3'd0 || q_done !== 1'b0) begin n_fail++; $display("FAIL ar_wrap got=%0h/%0d/%0h exp=0/0/0", q_overflow, q_count, q_done); end
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0 || count !== 6'd0) begin n_fail++; $display("FAIL ar_idle got=%0h/%0d exp=0/0", busy, count); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_event();
        test_restart_and_stop();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_trace_recorder.md
Name: wb_trace_recorder

Overview:
- Synthesizable on-chip successor to the bench-side PC/write-back logger for the multicycle RISC-V core.
- Captures {PC, WriteBackData} pairs into a parametrised circular buffer, either periodically or on every write-back event.
- Supports one-shot or wrap-around capture and a random-access readout port.
- Sits beside the core, fed by its PC and WriteBackData outputs; read by a debug controller or testbench.

Parameters:
- PC_W, 32, width of captured PC.
- DATA_W, 32, width of captured write-back data.
- DEPTH, 32, entries in the buffer; must be a power of two, at least 2.
- INTERVAL, 5, clock cycles between samples in periodic mode; at least 1.
- WRAP, 0. 0: one-shot, stop when full. 1: circular, overwrite oldest.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  pulse: arm and begin capture.
- stop  input  1  pulse: end capture.
- sample_mode  input  1  0: periodic every INTERVAL cycles; 1: sample when wb_valid. Latched on accepted start.
- pc_in  input  PC_W  PC to capture.
- wb_data_in  input  DATA_W  write-back data to capture.
- wb_valid  input  1  write-back event qualifier; used in mode 1 only.
- rd_en  input  1  read request.
- rd_addr  input  log2(DEPTH)  logical index; 0 = oldest stored entry.
- rd_pc  output  PC_W  read PC.
- rd_data  output  DATA_W  read write-back data.
- rd_valid  output  1  high one cycle after rd_en.
- busy  output  1  state is CAPTURE.
- done  output  1  state is DONE.
- count  output  log2(DEPTH)+1  valid entries, saturates at DEPTH.
- overflow  output  1  at least one entry has been overwritten (WRAP=1 only).

Behaviour:
- Reset (rst=0, asynchronous):
  - State IDLE; wr_ptr, interval counter, count, overflow, busy, done, rd_valid all 0.
  - rd_pc and rd_data are 0. Buffer contents are undefined.
- States: IDLE, CAPTURE, DONE.
- start in IDLE or DONE:
  - Clears wr_ptr, count, overflow and the interval counter.
  - Latches sample_mode.
  - Enters CAPTURE on the next edge.
  - start while in CAPTURE is ignored.
- Periodic mode, sample condition:
  - The interval counter runs 0..INTERVAL-1, starting at 0 on the first CAPTURE cycle.
  - A sample is taken in the cycle where the counter equals INTERVAL-1; the counter then returns to 0.
  - The first sample is therefore taken INTERVAL cycles after entering CAPTURE.
- Event mode, sample condition: a sample is taken in every CAPTURE cycle with wb_valid=1; back-to-back samples are allowed.
- Sample action:
  - Write {pc_in, wb_data_in} at wr_ptr.
  - wr_ptr increments modulo DEPTH.
  - count increments and saturates at DEPTH.
- Full, WRAP=0: the sample that makes count=DEPTH is stored, then the block enters DONE on the same edge. No further writes.
- Full, WRAP=1: capture continues. Each write while count=DEPTH overwrites the oldest entry and sets overflow=1.
- stop in CAPTURE:
  - Enters DONE on the next edge.
  - A sample due in the same cycle is still stored.
  - stop in IDLE or DONE is ignored.
- start and stop in the same cycle while in CAPTURE: stop wins, start is ignored.
- Readout:
  - Physical index = (base + rd_addr) mod DEPTH, where base = overflow ? wr_ptr : 0.
  - Latency is 1 cycle: rd_pc, rd_data and rd_valid update on the edge after rd_en.
  - rd_addr >= count returns rd_pc=0 and rd_data=0, with rd_valid=1.
  - rd_pc and rd_data hold their value while rd_en=0; rd_valid drops to 0.
  - Reads are legal in any state.
  - A read and a write to the same physical entry in the same cycle return the old contents.
- Reset mid-capture: immediately forces IDLE and clears all counters and flags. Stored data is not guaranteed.

Test Plan:
- Periodic one-shot, defaults:
  - Stimulus: start at cycle 0; pc_in=4*cycle, wb_data_in=cycle.
  - Response: samples at cycles 5, 10, ... 160. done=1 after the 32nd sample.
  - Read rd_addr=0 -> rd_pc=0x14, rd_data=0x5; rd_addr=31 -> rd_pc=0x280.
- Event mode:
  - Stimulus: wb_valid high on 3 consecutive cycles with data 0xA, 0xB, 0xC, then stop.
  - Response: count=3, done=1. Reads 0..2 return 0xA, 0xB, 0xC. rd_addr=3 returns 0 with rd_valid=1.
- WRAP=1, DEPTH=4, event mode:
  - Stimulus: 6 samples with data 1..6.
  - Response: overflow=1, count=4. Reads 0..3 return 3, 4, 5, 6.
- Same-cycle stop and sample:
  - Stimulus: stop asserted on the INTERVAL-1 cycle.
  - Response: that sample is stored, count increments, DONE is entered on the next edge.
- Asynchronous reset mid-capture:
  - Stimulus: rst=0 between clock edges during CAPTURE, with count=7.
  - Response: busy=0, count=0, overflow=0 and done=0 immediately, without waiting for a clock edge.
- Restart:
  - Stimulus: start pulse while in DONE.
  - Response: count clears to 0 and capture resumes. A start pulse while in CAPTURE has no effect on count.
